// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the NOP word and
// the helper that picks REQ or FAULT for a new fetch PC.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StOut   = 3'd3,
        StDrop  = 3'd4,
        StFault = 3'd5
    } fetch_state_e;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    function automatic fetch_state_e issue_or_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) ? StFault : StReq;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and fetch-to-decode handoff signals.
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_PC;
    logic [31:0] if_instr;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_PC, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_PC, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID holding register: captures a fetched instruction on load and
// keeps it until flushed by a handoff or redirect.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= 32'h0000_0000;
            r_instr <= NopInstr;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding imem request, redirect flushing,
// misaligned-PC fault, and a registered handoff to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         next_PC,
    input  logic                redirect,
    output logic [31:0]         PC,
    output logic                fetch_fault,
    fetch_unit_if.master        bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic         w_load;
    logic         w_flush;
    logic         w_req_valid;
    logic         w_fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_req_valid  = 1'b0;
        w_fault      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (redirect) begin
                    w_pc_next    = next_PC;
                    w_state_next = issue_or_fault(next_PC);
                end else begin
                    w_state_next = issue_or_fault(r_pc);
                end
            end
            StReq: begin
                w_req_valid = 1'b1;
                if (redirect) begin
                    w_pc_next    = next_PC;
                    // An accepted request still owes a response that must be discarded
                    w_state_next = bus.imem_req_ready ? StDrop : issue_or_fault(next_PC);
                end else if (bus.imem_req_ready) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (redirect) begin
                    w_pc_next    = next_PC;
                    w_state_next = bus.imem_rsp_valid ? issue_or_fault(next_PC) : StDrop;
                end else if (bus.imem_rsp_valid) begin
                    w_load       = 1'b1;
                    w_state_next = StOut;
                end
            end
            StOut: begin
                if (redirect || bus.if_ready) begin
                    w_pc_next    = next_PC;
                    w_flush      = 1'b1;
                    w_state_next = issue_or_fault(next_PC);
                end
            end
            StDrop: begin
                if (redirect) begin
                    w_pc_next = next_PC;
                    // The stale response landing this cycle clears the debt; don't wait again
                    w_state_next = bus.imem_rsp_valid ? issue_or_fault(next_PC) : StDrop;
                end else if (bus.imem_rsp_valid) begin
                    w_state_next = issue_or_fault(r_pc);
                end
            end
            StFault: begin
                w_fault = 1'b1;
                if (redirect) begin
                    w_pc_next    = next_PC;
                    w_state_next = issue_or_fault(next_PC);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_instr (bus.imem_rsp_data),
        .o_valid (bus.if_valid),
        .o_pc    (bus.if_PC),
        .o_instr (bus.if_instr)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign PC                 = r_pc;
    assign fetch_fault        = w_fault;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-low (0 = reset).
REQ-004 next_PC  input  32  SHALL be the next fetch address selected by the PC mux.
REQ-005 redirect  input  1  SHALL mark next_PC as a non-sequential target (branch/jump) that flushes fetch.
REQ-006 PC  output  32  SHALL be the current fetch PC, driven to the PC+4/PC+imm adders.
REQ-007 imem_req_valid  output  1 / imem_req_ready  input  1 / imem_addr  output  32 SHALL form the instruction-memory request handshake.
REQ-008 imem_rsp_valid  input  1 / imem_rsp_data  input  32 SHALL form the response; no back-pressure on responses.
REQ-009 if_valid  output  1 / if_ready  input  1 / if_PC  output  32 / if_instr  output  32 SHALL form the handoff to decode.
REQ-010 fetch_fault  output  1 SHALL flag a misaligned fetch PC.

Function
REQ-011 States SHALL be IDLE, REQ, WAIT, OUT, DROP, FAULT; at most one memory request outstanding.
REQ-012 IDLE SHALL last exactly one cycle after rst deasserts, then go to REQ (or FAULT if PC[1:0]!=0).
REQ-013 REQ: imem_req_valid=1, imem_addr=PC; on imem_req_ready=1 go to WAIT.
REQ-014 WAIT: on imem_rsp_valid=1 register if_instr<=imem_rsp_data, if_PC<=PC, go to OUT.
REQ-015 OUT: if_valid=1; on if_ready=1 load PC<=next_PC, go to REQ (FAULT if next_PC[1:0]!=0).
REQ-016 Best-case throughput SHALL be one instruction per 3 cycles (REQ, WAIT, OUT) with zero-latency memory.
REQ-017 if_valid SHALL be 1 only in OUT; if_PC/if_instr SHALL be stable while if_valid=1 and if_ready=0.
REQ-018 redirect=1 in any state SHALL load PC<=next_PC that cycle and take priority over all other transitions.
REQ-019 Redirect in REQ with imem_req_ready=1 -> DROP; with imem_req_ready=0 -> REQ, imem_addr takes new PC next cycle (memory tolerates address change before acceptance).
REQ-020 Redirect in WAIT with imem_rsp_valid=0 -> DROP; with imem_rsp_valid=1 -> response discarded, go to REQ.
REQ-021 DROP SHALL discard the next response (if_valid stays 0), then go to REQ; a further redirect in DROP updates PC and stays in DROP.
REQ-022 Redirect in OUT SHALL drop if_valid next cycle; a simultaneous if_ready=1 handshake SHALL be treated as flushed by decode; PC loads next_PC once; go to REQ.
REQ-023 Redirect in IDLE or FAULT SHALL go to REQ (FAULT if the new PC is misaligned).
REQ-024 FAULT: fetch_fault=1, no requests, if_valid=0, until redirect.
REQ-025 PC SHALL change only on reset, REQ-015 handoff, or redirect; PC arithmetic SHALL not occur in this block.

Reset
REQ-026 rst=0 SHALL immediately force: state IDLE, PC=RESET_PC, if_PC=0, if_instr=32'h0000_0013 (NOP), imem_req_valid=0, if_valid=0, fetch_fault=0.
REQ-027 Reset mid-transaction SHALL abandon any outstanding request; a response arriving in IDLE SHALL be ignored.

Structure
REQ-028 State encoding (3-bit) and NOP constant SHALL live in the shared CPU package; RESET_PC stays a module parameter.
REQ-029 The output holding register (if_PC, if_instr, if_valid) SHALL be a sub-module if_id_reg with load and flush inputs.
REQ-030 Next-state logic SHALL be a single combinational case on state; registers SHALL use one asynchronous-reset always block per register group.

Verification
REQ-031 Reset release, zero-latency memory returning 32'h00500093 at 0, if_ready=1, next_PC=PC+4 -> if_valid pulses with if_PC=0,4,8 every 3 cycles.
REQ-032 if_ready=0 for 5 cycles in OUT -> if_valid, if_PC=0x4, if_instr held; PC unchanged at 0x4; no imem request.
REQ-033 redirect=1, next_PC=0x100 in WAIT, response arrives next cycle -> response dropped, next request imem_addr=0x100, no if_valid for old PC.
REQ-034 redirect=1, next_PC=0x102 -> fetch_fault=1, imem_req_valid=0; then redirect to 0x200 -> fault clears, request at 0x200.
REQ-035 imem_req_ready held 0 for 3 cycles with redirect to 0x40 in cycle 2 -> accepted address is 0x40.
REQ-036 rst=0 asserted during WAIT -> PC=RESET_PC, if_valid=0 asynchronously; late response ignored; fetch restarts at RESET_PC.
